// File: rtl/tx_sync_header_gen_if.sv
// Bundle between the header generator, its PN/channel source and the TX modulator.
// The master side drives start/abort/PN words; the slave side is the generator.
interface tx_sync_header_gen_if;
  logic        start_in;
  logic        abort_in;
  logic [31:0] corr_tr_s0;
  logic [31:0] sync_pn_in;
  logic [3:0]  sync_hop_chan_in;
  logic        sync_pn_hop_en_in;
  logic        pn_req_out;
  logic        chip_out;
  logic        chip_strobe_out;
  logic        hop_start_out;
  logic [3:0]  hop_chan_out;
  logic        tr_phase_out;
  logic        busy_out;
  logic        done_out;
  logic        pn_overrun_out;
  logic [31:0] debug_signal;

  modport master (
    output start_in, abort_in, corr_tr_s0, sync_pn_in, sync_hop_chan_in, sync_pn_hop_en_in,
    input  pn_req_out, chip_out, chip_strobe_out, hop_start_out, hop_chan_out,
           tr_phase_out, busy_out, done_out, pn_overrun_out, debug_signal
  );

  modport slave (
    input  start_in, abort_in, corr_tr_s0, sync_pn_in, sync_hop_chan_in, sync_pn_hop_en_in,
    output pn_req_out, chip_out, chip_strobe_out, hop_start_out, hop_chan_out,
           tr_phase_out, busy_out, done_out, pn_overrun_out, debug_signal
  );
endinterface

// File: rtl/tx_sync_header_gen.sv
// Serialises SYNC_HOPS PN-word hops followed by TR_HOPS hops of the TR S0 code,
// MSB first, one chip every CHIP_DIV logic-clock cycles, with per-hop channel tagging.
module tx_sync_header_gen #(
  parameter int CHIP_DIV  = 8,
  parameter int SYNC_HOPS = 16,
  parameter int TR_HOPS   = 4
) (
  input  logic                 logic_clk_in,
  input  logic                 logic_rst_in,
  tx_sync_header_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CHIP_DIV - 1);
  localparam logic [4:0] SYNC_LIM  = 5'(SYNC_HOPS);
  localparam logic [4:0] HOP_LAST  = 5'(SYNC_HOPS + TR_HOPS - 1);
  localparam logic [4:0] CHIP_LAST = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  hop_cnt_q, hop_cnt_d;
  logic [4:0]  chip_cnt_q, chip_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [31:0] tr_code_q, tr_code_d;
  logic [31:0] pn_sr_q, pn_sr_d;
  logic        pn_req_q, pn_req_d;
  logic        chip_q, chip_d;
  logic        chip_strobe_q, chip_strobe_d;
  logic        hop_start_q, hop_start_d;
  logic [3:0]  hop_chan_q, hop_chan_d;
  logic        tr_phase_q, tr_phase_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pn_overrun_q, pn_overrun_d;
  logic [31:0] debug_q, debug_d;
  logic [31:0] load_word;

  // TR hops take their chips from the code captured at start; the live PN input is ignored.
  assign load_word = (hop_cnt_q < SYNC_LIM) ? bus.sync_pn_in : tr_code_q;

  always_comb begin
    state_d       = state_q;
    hop_cnt_d     = hop_cnt_q;
    chip_cnt_d    = chip_cnt_q;
    div_cnt_d     = div_cnt_q;
    tr_code_d     = tr_code_q;
    pn_sr_d       = pn_sr_q;
    chip_d        = chip_q;
    hop_chan_d    = hop_chan_q;
    chip_strobe_d = 1'b0;
    hop_start_d   = 1'b0;
    done_d        = 1'b0;
    pn_overrun_d  = 1'b0;

    if (bus.abort_in) begin
      state_d    = IDLE;
      hop_cnt_d  = '0;
      chip_cnt_d = '0;
      div_cnt_d  = '0;
      tr_code_d  = '0;
      pn_sr_d    = '0;
      chip_d     = 1'b0;
      hop_chan_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pn_overrun_d = bus.sync_pn_hop_en_in;
          if (bus.start_in) begin
            state_d   = LOAD;
            tr_code_d = bus.corr_tr_s0;
            hop_cnt_d = '0;
          end
        end
        LOAD: begin
          if (bus.sync_pn_hop_en_in) begin
            state_d       = SEND;
            hop_chan_d    = bus.sync_hop_chan_in;
            chip_d        = load_word[31];
            pn_sr_d       = {load_word[30:0], 1'b0};
            chip_cnt_d    = '0;
            div_cnt_d     = '0;
            chip_strobe_d = 1'b1;
            hop_start_d   = 1'b1;
          end
        end
        SEND: begin
          pn_overrun_d = bus.sync_pn_hop_en_in;
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (chip_cnt_q == CHIP_LAST) begin
              chip_cnt_d = '0;
              chip_d     = 1'b0;
              if (hop_cnt_q == HOP_LAST) begin
                state_d    = IDLE;
                done_d     = 1'b1;
                hop_cnt_d  = '0;
                hop_chan_d = '0;
              end else begin
                state_d   = LOAD;
                hop_cnt_d = hop_cnt_q + 5'd1;
              end
            end else begin
              chip_cnt_d    = chip_cnt_q + 5'd1;
              chip_d        = pn_sr_q[31];
              pn_sr_d       = {pn_sr_q[30:0], 1'b0};
              chip_strobe_d = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status outputs are registered from next-state values so they line up with the state.
    pn_req_d   = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    tr_phase_d = (state_d != IDLE) && (hop_cnt_d >= SYNC_LIM);
    debug_d    = {state_d, hop_cnt_d, chip_cnt_d, div_cnt_d, 12'b0};
  end

  always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
    if (!logic_rst_in) begin
      state_q       <= IDLE;
      hop_cnt_q     <= '0;
      chip_cnt_q    <= '0;
      div_cnt_q     <= '0;
      tr_code_q     <= '0;
      pn_sr_q       <= '0;
      pn_req_q      <= 1'b0;
      chip_q        <= 1'b0;
      chip_strobe_q <= 1'b0;
      hop_start_q   <= 1'b0;
      hop_chan_q    <= '0;
      tr_phase_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pn_overrun_q  <= 1'b0;
      debug_q       <= '0;
    end else begin
      state_q       <= state_d;
      hop_cnt_q     <= hop_cnt_d;
      chip_cnt_q    <= chip_cnt_d;
      div_cnt_q     <= div_cnt_d;
      tr_code_q     <= tr_code_d;
      pn_sr_q       <= pn_sr_d;
      pn_req_q      <= pn_req_d;
      chip_q        <= chip_d;
      chip_strobe_q <= chip_strobe_d;
      hop_start_q   <= hop_start_d;
      hop_chan_q    <= hop_chan_d;
      tr_phase_q    <= tr_phase_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pn_overrun_q  <= pn_overrun_d;
      debug_q       <= debug_d;
    end
  end

  assign bus.pn_req_out      = pn_req_q;
  assign bus.chip_out        = chip_q;
  assign bus.chip_strobe_out = chip_strobe_q;
  assign bus.hop_start_out   = hop_start_q;
  assign bus.hop_chan_out    = hop_chan_q;
  assign bus.tr_phase_out    = tr_phase_q;
  assign bus.busy_out        = busy_q;
  assign bus.done_out        = done_q;
  assign bus.pn_overrun_out  = pn_overrun_q;
  assign bus.debug_signal    = debug_q;

endmodule

// File: tb/tb_tx_sync_header_gen.sv
// Directed bench for tx_sync_header_gen: a CHIP_DIV=8 instance runs every header scenario,
// a CHIP_DIV=2 instance runs the short-chip nominal header.
module tb_tx_sync_header_gen;

  localparam int DIV_A = 8;
  localparam int DIV_B = 2;
  localparam logic [31:0] TR_CODE = 32'h1234ABCD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   edges = 0;
  int   total_strobes = 0;
  int   total_starts = 0;

  always #5 clk = ~clk;

  tx_sync_header_gen_if bus_a ();
  tx_sync_header_gen_if bus_b ();

  tx_sync_header_gen #(.CHIP_DIV(DIV_A), .SYNC_HOPS(16), .TR_HOPS(4)) dut_a (
    .logic_clk_in (clk),
    .logic_rst_in (rst_n),
    .bus          (bus_a.slave)
  );

  tx_sync_header_gen #(.CHIP_DIV(DIV_B), .SYNC_HOPS(16), .TR_HOPS(4)) dut_b (
    .logic_clk_in (clk),
    .logic_rst_in (rst_n),
    .bus          (bus_b.slave)
  );

  function automatic logic [31:0] exp_word(input int h);
    return (h < 16) ? (32'hA5A50F0F + 32'(h)) : TR_CODE;
  endfunction

  function automatic logic [43:0] outs_a();
    return {bus_a.pn_req_out, bus_a.chip_out, bus_a.chip_strobe_out, bus_a.hop_start_out,
            bus_a.hop_chan_out, bus_a.tr_phase_out, bus_a.busy_out, bus_a.done_out,
            bus_a.pn_overrun_out, bus_a.debug_signal};
  endfunction

  function automatic logic [43:0] outs_b();
    return {bus_b.pn_req_out, bus_b.chip_out, bus_b.chip_strobe_out, bus_b.hop_start_out,
            bus_b.hop_chan_out, bus_b.tr_phase_out, bus_b.busy_out, bus_b.done_out,
            bus_b.pn_overrun_out, bus_b.debug_signal};
  endfunction

  task automatic tick();
    @(negedge clk);
    edges++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic abort, input logic en,
                               input logic [31:0] pn, input logic [3:0] chan);
    bus_a.start_in          = start;
    bus_a.abort_in          = abort;
    bus_a.sync_pn_hop_en_in = en;
    bus_a.sync_pn_in        = pn;
    bus_a.sync_hop_chan_in  = chan;
  endtask

  // One header on dut_a; optional PN stall, overrun strobe, abort or reset at a given hop/cycle.
  task automatic run_header(input int delay_hop, input int delay_len, input int ov_hop, input int ov_at,
                            input int abort_hop, input int abort_at, input int rst_hop, input int rst_at,
                            input int exp_len);
    int start_mark, bad, ovs, stall_bad, idle_bad;
    logic [31:0] w;
    total_strobes = 0;
    total_starts  = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    start_mark = edges;
    checkOutput("start_busy", 64'(bus_a.busy_out), 64'd1);
    for (int h = 0; h < 20; h++) begin
      checkOutput($sformatf("load_req_h%0d", h), 64'(bus_a.pn_req_out), 64'd1);
      checkOutput($sformatf("load_tr_h%0d", h), 64'(bus_a.tr_phase_out), 64'(h >= 16));
      if (h == delay_hop) begin
        stall_bad = 0;
        for (int c = 0; c < delay_len; c++) begin
          if (bus_a.pn_req_out !== 1'b1 || bus_a.chip_out !== 1'b0) stall_bad++;
          tick();
        end
        checkOutput("pn_stall", 64'(stall_bad), 64'd0);
      end
      w = exp_word(h);
      applyStimulus(1'b0, 1'b0, 1'b1, (h < 16) ? w : 32'hDEADBEEF, 4'(h % 8));
      tick();
      checkOutput($sformatf("send_req_h%0d", h), 64'(bus_a.pn_req_out), 64'd0);
      bad = 0;
      ovs = 0;
      for (int i = 0; i < 32 * DIV_A; i++) begin
        if (h == ov_hop && i == ov_at) applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF0000, 4'hF);
        else                           applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        if (h == abort_hop && i == abort_at) begin
          applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
          tick();
          applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
          checkOutput("abort_outs", 64'(outs_a()), 64'd0);
          idle_bad = 0;
          for (int c = 0; c < 300; c++) begin
            if (bus_a.busy_out !== 1'b0 || bus_a.done_out !== 1'b0 || bus_a.pn_req_out !== 1'b0) idle_bad++;
            tick();
          end
          checkOutput("abort_idle", 64'(idle_bad), 64'd0);
          return;
        end
        if (h == rst_hop && i == rst_at) begin
          #1 rst_n = 1'b0;
          #1 checkOutput("reset_async_outs", 64'(outs_a()), 64'd0);
          tick();
          tick();
          rst_n = 1'b1;
          idle_bad = 0;
          for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_a.busy_out !== 1'b0 || bus_a.pn_req_out !== 1'b0) idle_bad++;
          end
          checkOutput("reset_idle", 64'(idle_bad), 64'd0);
          return;
        end
        if (h == 2 && i == 83)
          checkOutput("debug_word", 64'(bus_a.debug_signal), 64'({2'd2, 5'd2, 5'd10, 8'd3, 12'd0}));
        if (bus_a.chip_out !== w[31 - i / DIV_A]) bad++;
        if (bus_a.chip_strobe_out !== ((i % DIV_A) == 0)) bad++;
        if (bus_a.hop_start_out !== (i == 0)) bad++;
        if (bus_a.hop_chan_out !== 4'(h % 8)) bad++;
        if (bus_a.tr_phase_out !== (h >= 16)) bad++;
        total_strobes += int'(bus_a.chip_strobe_out);
        total_starts  += int'(bus_a.hop_start_out);
        ovs           += int'(bus_a.pn_overrun_out);
        tick();
      end
      checkOutput($sformatf("hop_chips_h%0d", h), 64'(bad), 64'd0);
      checkOutput($sformatf("hop_overrun_h%0d", h), 64'(ovs), 64'(h == ov_hop));
    end
    checkOutput("done_pulse", 64'(bus_a.done_out), 64'd1);
    checkOutput("done_busy", 64'(bus_a.busy_out), 64'd0);
    checkOutput("header_len", 64'(edges - start_mark), 64'(exp_len));
    checkOutput("chip_strobes", 64'(total_strobes), 64'd640);
    checkOutput("hop_starts", 64'(total_starts), 64'd20);
    tick();
    checkOutput("done_single", 64'(bus_a.done_out), 64'd0);
  endtask

  initial begin
    int mark_b, hop_in, hop_out, bit_idx, strobes_b, send_b, bad_b, done_at;
    logic [31:0] cur_word;
    logic last_chip;

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    bus_a.corr_tr_s0        = TR_CODE;
    bus_b.corr_tr_s0        = TR_CODE;
    bus_b.start_in          = 1'b0;
    bus_b.abort_in          = 1'b0;
    bus_b.sync_pn_hop_en_in = 1'b0;
    bus_b.sync_pn_in        = 32'h0;
    bus_b.sync_hop_chan_in  = 4'h0;
    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("reset_outs_a", 64'(outs_a()), 64'd0);
    checkOutput("reset_outs_b", 64'(outs_b()), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checkOutput("post_reset_idle", 64'(outs_a()), 64'd0);

    $display("[TB] nominal header");
    run_header(-1, 0, -1, 0, -1, 0, -1, 0, 5140);

    $display("[TB] slow PN source on hop 3");
    run_header(3, 50, -1, 0, -1, 0, -1, 0, 5190);

    $display("[TB] overrun in SEND of hop 0 and in IDLE");
    run_header(-1, 0, 0, 100, -1, 0, -1, 0, 5140);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0BADF00D, 4'h3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    checkOutput("idle_overrun", 64'(bus_a.pn_overrun_out), 64'd1);
    checkOutput("idle_overrun_busy", 64'(bus_a.busy_out), 64'd0);
    tick();
    checkOutput("idle_overrun_single", 64'(bus_a.pn_overrun_out), 64'd0);

    $display("[TB] abort at chip 10 of hop 5 with simultaneous start");
    run_header(-1, 0, -1, 0, 5, 10 * DIV_A, -1, 0, 0);
    run_header(-1, 0, -1, 0, -1, 0, -1, 0, 5140);

    $display("[TB] reset during hop 17");
    run_header(-1, 0, -1, 0, -1, 0, 17, 50, 0);
    run_header(-1, 0, -1, 0, -1, 0, -1, 0, 5140);

    $display("[TB] CHIP_DIV=2 header");
    bus_b.start_in = 1'b1;
    tick();
    bus_b.start_in = 1'b0;
    mark_b = edges;
    hop_in = 0; hop_out = 0; bit_idx = 0; strobes_b = 0; send_b = 0; bad_b = 0; done_at = 0;
    cur_word = 32'h0;
    last_chip = 1'b0;
    for (int c = 0; c < 1400 && done_at == 0; c++) begin
      bus_b.sync_pn_hop_en_in = 1'b0;
      if (bus_b.done_out === 1'b1) begin
        done_at = edges - mark_b;
      end else begin
        if (bus_b.pn_req_out === 1'b1) begin
          bus_b.sync_pn_hop_en_in = 1'b1;
          bus_b.sync_pn_in        = (hop_in < 16) ? exp_word(hop_in) : 32'h0;
          bus_b.sync_hop_chan_in  = 4'(hop_in % 8);
          hop_in++;
        end else if (bus_b.busy_out === 1'b1) begin
          send_b++;
          if (bus_b.hop_start_out === 1'b1) begin
            cur_word = exp_word(hop_out);
            hop_out++;
            bit_idx = 0;
          end else if (bus_b.chip_strobe_out === 1'b1) begin
            bit_idx++;
          end else if (bus_b.chip_out !== last_chip) begin
            bad_b++;
          end
          if (bit_idx > 31 || bus_b.chip_out !== cur_word[5'(31 - bit_idx)]) bad_b++;
          strobes_b += int'(bus_b.chip_strobe_out);
          last_chip = bus_b.chip_out;
        end
      end
      tick();
    end
    checkOutput("div2_header_len", 64'(done_at), 64'd1300);
    checkOutput("div2_strobes", 64'(strobes_b), 64'd640);
    checkOutput("div2_send_cycles", 64'(send_b), 64'd1280);
    checkOutput("div2_hops", 64'(hop_out), 64'd20);
    checkOutput("div2_chips", 64'(bad_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
